seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-segment multi-digit 7-segment display.
// Per-digit hex registers, blanking dead time, 16-level PWM and leading-zero blanking.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned DWELL_CYCLES   = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [3:0]            wr_data,
    input  logic [3:0]            brightness,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] sel,
    output logic                  frame_tick
);

    localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned MaxCnt = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam int unsigned Slice  = DWELL_CYCLES / 16;
    localparam logic [6:0]  SegOff = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {StBlank, StOn} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [3:0]            digits_q [NUM_DIGITS];
    logic [6:0]            pat_q;
    logic                  dark_q;
    logic [CntW-1:0]       lit_lim_q;
    logic                  wrap_q;
    logic                  on_entry, on_exit;
    logic [NUM_DIGITS-1:0] lz_dark;
    logic                  lz_run;
    logic [NUM_DIGITS-1:0] sel_d;
    logic [6:0]            seg_d;
    logic                  tick_d;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= 4'h0;
        end else if (wr_en && ({29'd0, wr_addr} < NUM_DIGITS)) begin
            digits_q[wr_addr[IdxW-1:0]] <= wr_data;
        end
    end

    // Digit i goes dark when it and every more-significant digit are zero.
    always_comb begin
        lz_run  = 1'b1;
        lz_dark = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run     = lz_run & (digits_q[i] == 4'h0);
            lz_dark[i] = lz_run;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q    <= StBlank;
            cnt_q      <= '0;
            idx_q      <= '0;
            pat_q      <= '0;
            dark_q     <= 1'b0;
            lit_lim_q  <= '0;
            wrap_q     <= 1'b0;
            sel        <= '0;
            seg        <= SegOff;
            frame_tick <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wrap_q     <= on_exit && (idx_q == LastIdx);
            sel        <= sel_d;
            seg        <= seg_d;
            frame_tick <= tick_d;
            // Slot contents are frozen here so mid-slot writes wait for the next slot.
            if (on_entry) begin
                pat_q     <= hex_decode(digits_q[idx_q]);
                dark_q    <= blank_lz && lz_dark[idx_q];
                lit_lim_q <= CntW'((32'(brightness) + 32'd1) * Slice);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CntW'(1);
        idx_d    = idx_q;
        on_entry = 1'b0;
        on_exit  = 1'b0;
        unique case (state_q)
            StBlank: begin
                if (cnt_q == CntW'(BLANK_CYCLES - 1)) begin
                    state_d  = StOn;
                    cnt_d    = '0;
                    on_entry = 1'b1;
                end
            end
            StOn: begin
                if (cnt_q == CntW'(DWELL_CYCLES - 1)) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    on_exit = 1'b1;
                    idx_d   = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
                end
            end
            default: state_d = StBlank;
        endcase
    end

    always_comb begin
        sel_d  = '0;
        seg_d  = SegOff;
        tick_d = wrap_q;
        if (state_q == StOn && !dark_q && cnt_q < lit_lim_q) begin
            sel_d[idx_q] = 1'b1;
            seg_d        = SEG_ACTIVE_LOW ? ~pat_q : pat_q;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: slot timing, PWM, leading-zero blanking, write latching,
// reset behaviour and a randomised select-spacing check.
module tb_seg_scan_ctrl;

    localparam int Frame = 144;
    localparam int Slot  = 36;

    logic       CLOCK_50;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] brightness;
    logic       blank_lz;
    logic [6:0] seg;
    logic [3:0] sel;
    logic       frame_tick;

    int n_total = 0;
    int n_bad   = 0;
    int cur_cyc = 0;
    int dig [4];
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_scan_ctrl #(
        .NUM_DIGITS    (4),
        .DWELL_CYCLES  (32),
        .BLANK_CYCLES  (4),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .brightness(brightness),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .sel       (sel),
        .frame_tick(frame_tick)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cur_cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Hold reset for three edges with a write pending; outputs must read dark throughout.
    task automatic apply_reset();
        reset   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            cur_cyc = -1;
            check("rst_sel", 32'(sel), 32'h0);
            check("rst_seg", 32'(seg), 32'h7F);
            check("rst_tick", 32'(frame_tick), 32'h0);
        end
        wr_en = 1'b0;
    endtask

    // Release reset and check every cycle against the slot-timing model.
    // Optional init writes digit c at cycle c (c<4); optional single write at wr_cyc.
    task automatic run(input int ncyc, input int lit, input bit lz, input bit init,
                       input int wr_cyc, input int wr_a, input int wr_d);
        int frame, pos, slot, off, lat;
        int v [4];
        bit dark, on;
        logic [3:0] esel;
        logic [6:0] eseg;
        reset    = 1'b1;
        blank_lz = lz;
        for (int c = 0; c < ncyc; c++) begin
            if (init && c < 4) begin
                wr_en = 1'b1; wr_addr = 3'(c); wr_data = 4'(dig[c]);
            end else if (c == wr_cyc) begin
                wr_en = 1'b1; wr_addr = 3'(wr_a); wr_data = 4'(wr_d);
            end else begin
                wr_en = 1'b0;
            end
            step();
            cur_cyc = c;
            frame = c / Frame;
            pos   = c % Frame;
            slot  = pos / Slot;
            off   = pos % Slot;
            lat   = frame * Frame + slot * Slot + 3;
            for (int j = 0; j < 4; j++)
                v[j] = (wr_cyc >= 0 && wr_a == j && wr_cyc < lat) ? wr_d : dig[j];
            dark = 1'b0;
            if (lz && slot > 0) begin
                dark = 1'b1;
                for (int j = slot; j < 4; j++) if (v[j] != 0) dark = 1'b0;
            end
            on   = (off >= 4) && ((off - 4) < lit) && !dark;
            esel = on ? 4'(1 << slot) : 4'h0;
            eseg = on ? ~hex_tab[v[slot]] : 7'h7F;
            check("sel", 32'(sel), 32'(esel));
            check("seg", 32'(seg), 32'(eseg));
            check("tick", 32'(frame_tick), 32'(c > 0 && pos == 0));
        end
        wr_en = 1'b0;
    endtask

    initial begin
        int zeros;
        logic [3:0] prev_sel;
        reset = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'h0;
        brightness = 4'd15; blank_lz = 1'b0;

        apply_reset();
        dig = '{4, 3, 2, 1};
        run(300, 32, 1'b0, 1'b1, -1, 0, 0);

        apply_reset();
        brightness = 4'd3;
        run(300, 8, 1'b0, 1'b1, -1, 0, 0);

        apply_reset();
        brightness = 4'd0;
        run(150, 2, 1'b0, 1'b1, -1, 0, 0);

        brightness = 4'd15;
        apply_reset();
        dig = '{0, 7, 0, 0};
        run(288, 32, 1'b1, 1'b1, -1, 0, 0);
        apply_reset();
        run(160, 32, 1'b0, 1'b1, -1, 0, 0);

        dig = '{4, 3, 2, 1};
        apply_reset();
        run(300, 32, 1'b0, 1'b1, 90, 2, 'hA);
        apply_reset();
        run(200, 32, 1'b0, 1'b1, 39, 1, 9);
        apply_reset();
        run(200, 32, 1'b0, 1'b1, 10, 4, 8);

        // Reset in the middle of digit 1's lit window; digits must come back as zero.
        apply_reset();
        run(50, 32, 1'b0, 1'b1, -1, 0, 0);
        apply_reset();
        dig = '{0, 0, 0, 0};
        run(80, 32, 1'b0, 1'b0, -1, 0, 0);

        apply_reset();
        reset = 1'b1;
        zeros = 0;
        prev_sel = 4'h0;
        for (int c = 0; c < 20 * Frame; c++) begin
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_addr    = 3'($urandom_range(0, 7));
            wr_data    = 4'($urandom_range(0, 15));
            brightness = 4'($urandom_range(0, 15));
            blank_lz   = 1'($urandom_range(0, 1));
            step();
            cur_cyc = c;
            check("onehot", 32'($onehot0(sel)), 32'h1);
            check("rnd_tick", 32'(frame_tick), 32'(c > 0 && c % Frame == 0));
            if (sel != 4'h0) begin
                if (prev_sel != 4'h0 && sel != prev_sel)
                    check("gap", 32'(zeros >= 4), 32'h1);
                zeros    = 0;
                prev_sel = sel;
            end else begin
                zeros++;
            end
        end
        wr_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
